branch_pc_unit: RTL and testbench

- Parametrised successor to the single-flag branch decision: combines a condition-flag register, an 8-mode branch-condition evaluator and the program counter register.
- Sits between the ALU (flag source) and instruction fetch (PC consumer) in the custom processor.
- Adds multi-mode conditions, same-cycle flag forwarding, stall handling, a one-cycle flush pulse and a saturating taken-branch counter.

---
 rtl/branch_pc_unit_pkg.sv | 31 +++
 rtl/branch_cond_eval.sv | 34 +++
 rtl/branch_pc_unit.sv | 99 +++++++++
 tb/tb_branch_pc_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/branch_pc_unit_pkg.sv
// Shared processor-wide definitions: branch condition codes and the
// {Z,N,C,V} condition-flag layout.
package branch_pc_unit_pkg;

  // Branch condition codes as carried in the instruction.
  typedef enum logic [2:0] {
    COND_NEVER  = 3'b000,
    COND_ALWAYS = 3'b001,
    COND_EQ     = 3'b010,
    COND_NE     = 3'b011,
    COND_LT     = 3'b100,
    COND_GE     = 3'b101,
    COND_LTU    = 3'b110,
    COND_GEU    = 3'b111
  } cond_e;

  // Bit positions of each flag inside the 4-bit flag word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Structured view of the flag word; field order matches the bit positions.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: decides whether the presented
// condition code holds for the given effective flags.
module branch_cond_eval
  import branch_pc_unit_pkg::*;
(
  input  cond_e  branch_cond,
  input  flags_t eff_flags,
  output logic   cond_true
);

  logic signed_lt_s;

  // Signed less-than is N xor V; shared by LT and GE.
  always_comb begin
    signed_lt_s = eff_flags.n ^ eff_flags.v;
  end

  // Decode the condition code against the effective flags.
  always_comb begin
    cond_true = 1'b0;
    case (branch_cond)
      COND_NEVER:  cond_true = 1'b0;
      COND_ALWAYS: cond_true = 1'b1;
      COND_EQ:     cond_true = eff_flags.z;
      COND_NE:     cond_true = ~eff_flags.z;
      COND_LT:     cond_true = signed_lt_s;
      COND_GE:     cond_true = ~signed_lt_s;
      COND_LTU:    cond_true = ~eff_flags.c;
      COND_GEU:    cond_true = eff_flags.c;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch/PC unit: flag register with same-cycle forwarding, branch decision,
// program counter, one-cycle flush pulse and saturating taken-branch count.
// Every output is driven straight from a register.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int               PC_W        = 16,
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  parameter int               INSTR_BYTES = 4,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flags_we,
  input  logic [3:0]       alu_flags,
  input  logic             branch_valid,
  input  logic [2:0]       branch_cond,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       flags,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  // Sequential step and the mask that clears the sub-instruction address bits.
  localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0]  ALIGN_MASK = ~(PC_STEP - {{(PC_W-1){1'b0}}, 1'b1});
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [PC_W-1:0]  pc_r;
  logic [3:0]       flags_r;
  logic             flush_r;
  logic [CNT_W-1:0] taken_cnt_r;

  flags_t           eff_flags_s;
  logic             cond_true_s;
  logic             take_s;
  logic [PC_W-1:0]  pc_next_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Forward the ALU flags when they are written this cycle.
  always_comb begin
    eff_flags_s = flags_t'(flags_r);
    if (flags_we) begin
      eff_flags_s = flags_t'(alu_flags);
    end else begin
      eff_flags_s = flags_t'(flags_r);
    end
  end

  branch_cond_eval u_cond_eval (
    .branch_cond (cond_e'(branch_cond)),
    .eff_flags   (eff_flags_s),
    .cond_true   (cond_true_s)
  );

  // Branch decision, next PC and saturating counter increment.
  always_comb begin
    take_s     = branch_valid & ~stall & cond_true_s;
    pc_next_s  = pc_r;
    cnt_next_s = taken_cnt_r;
    if (stall) begin
      pc_next_s = pc_r;
    end else if (take_s) begin
      pc_next_s = branch_target & ALIGN_MASK;
    end else begin
      pc_next_s = pc_r + PC_STEP;
    end
    if (take_s && (taken_cnt_r != CNT_MAX)) begin
      cnt_next_s = taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = taken_cnt_r;
    end
  end

  // State registers; reset wins over stall and branch in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      flags_r     <= 4'b0000;
      flush_r     <= 1'b0;
      taken_cnt_r <= '0;
    end else begin
      pc_r        <= pc_next_s;
      flush_r     <= take_s;
      taken_cnt_r <= cnt_next_s;
      if (flags_we) begin
        flags_r <= alu_flags;
      end
    end
  end

  assign pc        = pc_r;
  assign flags     = flags_r;
  assign flush     = flush_r;
  assign taken_cnt = taken_cnt_r;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: a behavioural model predicts the
// post-edge state for every driven cycle, pushes it to a scoreboard queue and
// the entry is popped and compared after the clock edge. A second instance
// with a 2-bit counter shares the stimulus to exercise saturation.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flags_we;
  logic [3:0]  alu_flags;
  logic        branch_valid;
  logic [2:0]  branch_cond;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic [3:0]  flags;
  logic        flush;
  logic [7:0]  taken_cnt;
  logic [15:0] pc2;
  logic [3:0]  flags2;
  logic        flush2;
  logic [1:0]  taken_cnt2;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  flags;
    logic        flush;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Model state
  logic [15:0] m_pc;
  logic [3:0]  m_flags;
  logic        m_flush;
  int          m_cnt;
  int          m_cnt2;

  branch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flags_we(flags_we),
    .alu_flags(alu_flags), .branch_valid(branch_valid),
    .branch_cond(branch_cond), .branch_target(branch_target),
    .pc(pc), .flags(flags), .flush(flush), .taken_cnt(taken_cnt)
  );

  branch_pc_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flags_we(flags_we),
    .alu_flags(alu_flags), .branch_valid(branch_valid),
    .branch_cond(branch_cond), .branch_target(branch_target),
    .pc(pc2), .flags(flags2), .flush(flush2), .taken_cnt(taken_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_holds(input logic [2:0] c, input logic [3:0] f);
    logic z, n, cf, v;
    z = f[3]; n = f[2]; cf = f[1]; v = f[0];
    case (c)
      3'd0:    return 1'b0;
      3'd1:    return 1'b1;
      3'd2:    return z;
      3'd3:    return !z;
      3'd4:    return n != v;
      3'd5:    return n == v;
      3'd6:    return !cf;
      default: return cf;
    endcase
  endfunction

  // Drive one cycle, predict its outcome, then check after the edge.
  task automatic step(input logic r, input logic st, input logic we, input logic [3:0] af,
                      input logic bv, input logic [2:0] bc, input logic [15:0] bt);
    logic [3:0] eff;
    logic       tk;
    exp_t       e;
    exp_t       g;
    @(negedge clk);
    rst = r; stall = st; flags_we = we; alu_flags = af;
    branch_valid = bv; branch_cond = bc; branch_target = bt;
    eff = we ? af : m_flags;
    tk  = bv && !st && cond_holds(bc, eff);
    if (r) begin
      m_pc = 16'h0000; m_flags = 4'h0; m_flush = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (we) m_flags = af;
      if (!st) m_pc = tk ? {bt[15:2], 2'b00} : m_pc + 16'd4;
      m_flush = tk;
      if (tk && m_cnt < 255) m_cnt++;
      if (tk && m_cnt2 < 3) m_cnt2++;
    end
    e.pc = m_pc; e.flags = m_flags; e.flush = m_flush;
    e.cnt = 8'(m_cnt); e.cnt2 = 2'(m_cnt2);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      g = sb_q.pop_front();
      check("pc", 32'(pc), 32'(g.pc));
      check("flags", 32'(flags), 32'(g.flags));
      check("flush", 32'(flush), 32'(g.flush));
      check("taken_cnt", 32'(taken_cnt), 32'(g.cnt));
      check("taken_cnt_sat", 32'(taken_cnt2), 32'(g.cnt2));
      check("pc_inst2", 32'(pc2), 32'(g.pc));
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flags_we = 1'b0; alu_flags = 4'h0;
    branch_valid = 1'b0; branch_cond = 3'd0; branch_target = 16'h0000;
    m_pc = 16'h0000; m_flags = 4'h0; m_flush = 1'b0; m_cnt = 0; m_cnt2 = 0;

    // Reset then idle: pc 0, 4, 8, C
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0000);
    check("reset_pc_const", 32'(pc), 32'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0000);
    check("idle_pc_const", 32'(pc), 32'h000C);

    // Forwarded Z flag, EQ branch to unaligned 0x0102 -> 0x0100
    step(1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 3'd2, 16'h0102);
    check("fwd_pc_const", 32'(pc), 32'h0100);
    check("fwd_flush_const", 32'(flush), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0000);
    check("flush_drop_const", 32'(flush), 32'd0);

    // Clear flags, then three back-to-back NE branches
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd3, 16'h0200);
    check("b2b_cnt_const", 32'(taken_cnt), 32'd4);

    // Stall with a pending always-branch; flags still written on 2nd cycle
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 3'd1, 16'h0300);
    step(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 3'd1, 16'h0300);

    // Remaining condition codes with flags N=1 C=1
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd4, 16'h0404); // LT true
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd5, 16'h0500); // GE false
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd6, 16'h0600); // LTU false
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd7, 16'h0707); // GEU true
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd0, 16'h0800); // NEVER
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 16'h0900); // EQ false

    // PC wrap: branch to 0xFFFE (aligns to 0xFFFC), then sequential
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 16'hFFFE);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0000);
    check("wrap_pc_const", 32'(pc), 32'h0000);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
           1'($urandom), 3'($urandom), 16'($urandom));
    end

    // Reset coincident with a taken branch
    step(1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 3'd1, 16'h1234);
    check("rst_branch_cnt_const", 32'(taken_cnt), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
